// File: rtl/l2t_sii_iq_rcv.sv
// SII->L2T inbound request receiver: assembles 4-word packets into decoded
// entries, buffers them in a DEPTH-entry queue and returns credits on pop.
module l2t_sii_iq_rcv #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = 3
) (
    input  logic            iol2clk,
    input  logic            rst_l,
    input  logic [31:0]     sii_l2t_req,
    input  logic            sii_l2t_req_vld,
    input  logic            pipe_pop,
    output logic            iq_vld,
    output logic [3:0]      iq_opcode,
    output logic [2:0]      iq_cfg,
    output logic [13:0]     iq_tag,
    output logic [39:0]     iq_addr,
    output logic [63:0]     iq_data,
    output logic [CNTW-1:0] iq_cnt,
    output logic            l2t_sii_iq_dequeue,
    output logic            err_ovf,
    output logic            err_proto,
    output logic            err_opc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [3:0] OPC_RD64 = 4'b0001;
    localparam logic [3:0] OPC_WR8  = 4'b0010;
    localparam logic [3:0] OPC_WRI  = 4'b0100;

    typedef enum logic [1:0] {IDLE, A1, D2, D3} state_e;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [2:0]  cfg;
        logic [13:0] tag;
        logic [39:0] addr;
        logic [63:0] data;
    } entry_t;

    state_e          state_q, state_d;
    logic            cap_w0, cap_w1, cap_w2, last_w, proto_hit;

    logic [3:0]      opc_q;
    logic [2:0]      cfg_q;
    logic [13:0]     tag_q;
    logic [39:0]     addr_q;
    logic [31:0]     dhi_q;

    entry_t          mem_q [DEPTH];
    entry_t          new_entry, head;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            deq_q, ovf_q, proto_q, opc_err_q;
    logic            opc_legal, full, pop_acc, push, drop_ovf, drop_opc;

    // ---- assembly FSM ----
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sii_l2t_req_vld) state_d = A1;
            A1:      state_d = D2;
            D2:      state_d = D3;
            D3:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cap_w0    = (state_q == IDLE) && sii_l2t_req_vld;
        cap_w1    = (state_q == A1);
        cap_w2    = (state_q == D2);
        last_w    = (state_q == D3);
        proto_hit = (state_q != IDLE) && sii_l2t_req_vld;
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            opc_q  <= '0;
            cfg_q  <= '0;
            tag_q  <= '0;
            addr_q <= '0;
            dhi_q  <= '0;
        end else begin
            if (cap_w0) begin
                opc_q         <= sii_l2t_req[30:27];
                cfg_q         <= sii_l2t_req[26:24];
                tag_q         <= sii_l2t_req[21:8];
                addr_q[39:32] <= sii_l2t_req[7:0];
            end
            if (cap_w1) addr_q[31:0] <= sii_l2t_req;
            if (cap_w2) dhi_q        <= sii_l2t_req;
        end
    end

    // ---- queue control; w3 is taken straight from the bus in the D3 cycle ----
    assign opc_legal = (opc_q == OPC_RD64) || (opc_q == OPC_WR8) || (opc_q == OPC_WRI);
    assign full      = (cnt_q == CNTW'(DEPTH));
    assign pop_acc   = pipe_pop && (cnt_q != '0);
    assign push      = last_w && opc_legal && (!full || pop_acc);
    assign drop_ovf  = last_w && opc_legal && full && !pop_acc;
    assign drop_opc  = last_w && !opc_legal;

    always_comb begin
        new_entry.opcode = opc_q;
        new_entry.cfg    = cfg_q;
        new_entry.tag    = tag_q;
        new_entry.addr   = addr_q;
        new_entry.data   = (opc_q == OPC_WR8) ? {dhi_q, sii_l2t_req} : '0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop_acc)      cnt_d = cnt_q + CNTW'(1);
        else if (!push && pop_acc) cnt_d = cnt_q - CNTW'(1);
    end

    always_ff @(posedge iol2clk) begin
        if (push) mem_q[wr_ptr_q] <= new_entry;
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            deq_q     <= 1'b0;
            ovf_q     <= 1'b0;
            proto_q   <= 1'b0;
            opc_err_q <= 1'b0;
        end else begin
            if (push)    wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_acc) rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q     <= cnt_d;
            deq_q     <= pop_acc;
            ovf_q     <= ovf_q | drop_ovf;
            proto_q   <= proto_q | proto_hit;
            opc_err_q <= opc_err_q | drop_opc;
        end
    end

    // ---- head presentation, forced to zero while empty ----
    assign head = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;

    assign iq_vld             = (cnt_q != '0);
    assign iq_opcode          = head.opcode;
    assign iq_cfg             = head.cfg;
    assign iq_tag             = head.tag;
    assign iq_addr            = head.addr;
    assign iq_data            = head.data;
    assign iq_cnt             = cnt_q;
    assign l2t_sii_iq_dequeue = deq_q;
    assign err_ovf            = ovf_q;
    assign err_proto          = proto_q;
    assign err_opc            = opc_err_q;

endmodule

// File: doc/l2t_sii_iq_rcv.md
Name: l2t_sii_iq_rcv

Overview:
- L2T-side receiver for the SII→L2T inbound request channel. One instance per L2 bank.
- Assembles the 4-cycle packets on sii_l2t_req into decoded request entries and buffers them in a DEPTH-entry input queue (IQ).
- Presents the queue head to the L2 pipe through a valid/pop handshake.
- Returns one credit to SII per pop by pulsing l2t_sii_iq_dequeue.

Parameters:
- DEPTH, 4, number of IQ entries; power of 2, at least 2.
- CNTW, 3, width of iq_cnt; must hold the value DEPTH.

Ports:
- iol2clk  in  1  clock
- rst_l  in  1  asynchronous active-low reset
- sii_l2t_req  in  32  packet word
- sii_l2t_req_vld  in  1  marks word 0 (header) of a packet
- pipe_pop  in  1  L2 pipe consumes the head entry
- iq_vld  out  1  head entry valid
- iq_opcode  out  4  head opcode
- iq_cfg  out  3  head config
- iq_tag  out  14  head tag
- iq_addr  out  40  head physical address
- iq_data  out  64  head WR8 data; 0 for other opcodes
- iq_cnt  out  CNTW  occupied entries
- l2t_sii_iq_dequeue  out  1  credit-return pulse
- err_ovf  out  1  sticky: packet dropped because the IQ was full
- err_proto  out  1  sticky: req_vld seen mid-packet
- err_opc  out  1  sticky: packet with an illegal opcode dropped

Behaviour:
- Reset (async, rst_l=0):
  - FSM goes to IDLE; IQ pointers and iq_cnt are 0.
  - All outputs are 0, including the error flags.
  - A packet in flight is discarded and no entry is written.
  - Release is synchronous to iol2clk.
- Packet format, one word per cycle, 4 consecutive cycles:
  - w0 (vld=1): [30:27] opcode, [26:24] cfg, [21:8] tag, [7:0] addr[39:32]; [31], [23:22] ignored.
  - w1: addr[31:0].
  - w2: data[63:32].
  - w3: data[31:0]. Words w2 and w3 are dummy for non-WR8 opcodes and are captured but zeroed.
- Opcodes: 4'b0001 RD64; 4'b0010 WR8; 4'b0100 WRI. WRI data moves on the WIB path, which is out of scope for this block. Any other opcode is illegal.
- Assembly FSM: IDLE → A1 → D2 → D3 → IDLE.
  - IDLE: advance on vld=1, capturing w0.
  - A1: capture w1.
  - D2: capture w2.
  - D3: capture w3, then push.
  - vld=1 in A1, D2 or D3: set err_proto, ignore vld, and continue the current packet.
  - Back-to-back packets are legal: vld may be 1 in the IDLE cycle directly after D3.
- Push at the end of the D3 cycle:
  - Illegal opcode: no push; set err_opc.
  - Otherwise, if iq_cnt==DEPTH and no pop this cycle: drop the packet and set err_ovf.
  - Otherwise: write the entry at the write pointer.
- The entry is visible on iq_* the cycle after the push edge. Latency from w0 to iq_vld is 4 cycles when the queue was empty.
- iq_vld = (iq_cnt != 0). iq_* fields are driven combinationally from the head entry and are 0 when empty.
- Pop:
  - pipe_pop && iq_vld advances the read pointer at the edge.
  - pipe_pop while empty is ignored and does not pulse the credit.
- Push and pop in the same cycle, including when full: both take effect and iq_cnt is unchanged.
- Pointers are log2(DEPTH) bits wide and wrap naturally.
- l2t_sii_iq_dequeue is registered: exactly one 1-cycle pulse the cycle after each accepted pop. Pops in consecutive cycles produce consecutive pulses.
- Error flags are sticky until reset. Multiple errors may be set together.

Test Plan:
- Reset, then send RD64: w0=0x0801_2345, w1=0xDEAD_BEE0. Required response: 4 cycles after w0, iq_vld=1, opcode=1, cfg=0, tag=0x0123, addr=0x45_DEAD_BEE0, data=0, cnt=1. Assert pipe_pop for one cycle → cnt=0 and one dequeue pulse the next cycle.
- WR8 with w2=0x1111_2222, w3=0x3333_4444 → iq_data=0x1111_2222_3333_4444.
- Five back-to-back RD64 packets with no pops (DEPTH=4) → cnt=4 and err_ovf=1, with entries 0-3 intact. Then pop 4 times → 4 dequeue pulses and entries emerge in order, exercising pointer wrap.
- IQ full with pipe_pop=1 in the D3 cycle of a 5th packet → push accepted, cnt stays 4, no err_ovf.
- vld=1 during A1 → err_proto=1 and the original packet is still enqueued intact. Then send opcode 4'b1000 → err_opc=1 and cnt unchanged.
- Assert rst_l=0 during D2 with cnt=2 → immediately cnt=0, iq_vld=0 and errors cleared. After release, a new packet enqueues normally.
